// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: FSM states, access op, index width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_t;

    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and RAM-side signals of mem_arbiter; lock exists only with MEM_ARB_LOCK_EN.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 8,
    parameter int DW      = 8
);
    logic [NUM_REQ-1:0]    rden;
    logic [NUM_REQ-1:0]    wren;
    logic [NUM_REQ*AW-1:0] address;
    logic [NUM_REQ*DW-1:0] din;
    logic [NUM_REQ-1:0]    acq;
    logic [NUM_REQ*DW-1:0] dq;
    logic [AW-1:0]         ram_address;
    logic [DW-1:0]         ram_din;
    logic                  ram_wren;
    logic [DW-1:0]         ram_q;
    logic                  busy;
`ifdef MEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]    lock;
`endif

    modport master (
`ifdef MEM_ARB_LOCK_EN
        output lock,
`endif
        output rden, wren, address, din, ram_q,
        input  acq, dq, ram_address, ram_din, ram_wren, busy
    );

    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  lock,
`endif
        input  rden, wren, address, din, ram_q,
        output acq, dq, ram_address, ram_din, ram_wren, busy
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               valid
);

    logic [IW-1:0] idx;

    // Scan from farthest to nearest so the nearest requester is assigned last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM among NUM_REQ requesters.
// Define MEM_ARB_LOCK_EN to add the lock input for atomic read-modify-write sequences.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = 8,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    // state  | meaning
    // IDLE   | sample requests, latch the winner
    // ISSUE  | drive RAM address/data, write strobe for writes
    // RDWAIT | RAM output valid, capture into winner's dq slice
    // DONE   | acq pulse to winner, advance pointer

    localparam int IW = idx_width(NUM_REQ);

    arb_state_t           state, state_nxt;
    logic [NUM_REQ-1:0]   req;
    logic [IW-1:0]        ptr, win_idx, pick_idx, grant_idx, ptr_inc;
    logic                 pick_valid, grant_valid, hold_ptr;
    logic [AW-1:0]        lat_addr;
    logic [DW-1:0]        lat_din;
    arb_op_t              lat_op;
    logic [NUM_REQ*DW-1:0] dq_r;
    logic [NUM_REQ-1:0]   acq_c;
    logic                 ram_wren_c;
    logic                 busy_c;

    assign req = bus.rden | bus.wren;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

`ifdef MEM_ARB_LOCK_EN
    logic locked;
    logic lock_hit;

    // While locked, win_idx still names the lock owner from the last DONE.
    assign lock_hit    = locked & req[win_idx];
    assign grant_valid = lock_hit | pick_valid;
    assign grant_idx   = lock_hit ? win_idx : pick_idx;
    assign hold_ptr    = bus.lock[win_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (state == DONE) begin
            locked <= bus.lock[win_idx];
        end else if (state == IDLE && locked && !req[win_idx]) begin
            locked <= 1'b0;
        end
    end
`else
    assign grant_valid = pick_valid;
    assign grant_idx   = pick_idx;
    assign hold_ptr    = 1'b0;
`endif

    assign ptr_inc = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant_valid ? ISSUE : IDLE;
            ISSUE:   state_nxt = (lat_op == OP_WR) ? DONE : RDWAIT;
            RDWAIT:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acq_c      = '0;
        ram_wren_c = 1'b0;
        busy_c     = (state != IDLE);
        if (state == DONE) acq_c[win_idx] = 1'b1;
        if (state == ISSUE && lat_op == OP_WR) ram_wren_c = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            win_idx  <= '0;
            lat_addr <= '0;
            lat_din  <= '0;
            lat_op   <= OP_RD;
            dq_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        win_idx  <= grant_idx;
                        lat_addr <= bus.address[int'(grant_idx)*AW +: AW];
                        lat_din  <= bus.din[int'(grant_idx)*DW +: DW];
                        lat_op   <= bus.wren[grant_idx] ? OP_WR : OP_RD;
                    end
                end
                RDWAIT: dq_r[int'(win_idx)*DW +: DW] <= bus.ram_q;
                DONE: begin
                    if (!hold_ptr) ptr <= ptr_inc;
                end
                default: ;
            endcase
        end
    end

    // RAM address/data come straight from the latches, so they hold outside ISSUE.
    assign bus.ram_address = lat_addr;
    assign bus.ram_din     = lat_din;
    assign bus.ram_wren    = ram_wren_c;
    assign bus.acq         = acq_c;
    assign bus.dq          = dq_r;
    assign bus.busy        = busy_c;

endmodule
